icache_wishbone_refill: RTL and testbench

Refill bridge between the instruction cache's memory command/response port and the CPU instruction Wishbone bus. It accepts one line-refill command at a time and issues a Wishbone incrementing burst of `LINE_WORDS` reads. It returns each word to the cache as a one-cycle response pulse. Bus errors are converted into error-flagged responses, so the cache always receives exactly `LINE_WORDS` beats.

---
 rtl/icache_wishbone_refill_pkg.sv | 21 ++
 rtl/icache_wishbone_refill_if.sv | 64 ++++++
 rtl/icache_wishbone_refill.sv | 108 ++++++++++
 tb/tb_icache_wishbone_refill.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_wishbone_refill_pkg.sv
// Shared Wishbone constants and refill FSM encoding for the
// instruction-cache refill bridge.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } refill_state_e;

    function automatic logic [2:0] cti_for_beat(input logic last);
        return last ? CTI_END : CTI_INCR;
    endfunction

endpackage

// File: rtl/icache_wishbone_refill_if.sv
// Cache command/response port plus Wishbone master signals of the
// refill bridge, bundled so the bridge sees one port.
interface icache_wishbone_refill_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_address;

    logic                  rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_error;

    logic [ADDR_WIDTH-3:0] wb_adr;
    logic [31:0]           wb_dat_r;
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [3:0]            wb_sel;
    logic [2:0]            wb_cti;
    logic [1:0]            wb_bte;
    logic                  wb_ack;
    logic                  wb_err;

    modport master (
        input  cmd_valid,
        input  cmd_address,
        input  wb_dat_r,
        input  wb_ack,
        input  wb_err,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_error,
        output wb_adr,
        output wb_cyc,
        output wb_stb,
        output wb_we,
        output wb_sel,
        output wb_cti,
        output wb_bte
    );

    modport slave (
        output cmd_valid,
        output cmd_address,
        output wb_dat_r,
        output wb_ack,
        output wb_err,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_error,
        input  wb_adr,
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        input  wb_sel,
        input  wb_cti,
        input  wb_bte
    );

endinterface

// File: rtl/icache_wishbone_refill.sv
// I-cache line refill bridge: one command in, one incrementing
// Wishbone burst out, exactly LINE_WORDS responses back.
module icache_wishbone_refill
    import wb_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    icache_wishbone_refill_if.master bus
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BURST = ST_BURST;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [LINE_W-1:0] r_base;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [31:0]       r_rsp_data;

    logic w_idle;
    logic w_burst;
    logic w_drain;
    logic w_last;
    logic w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_burst  = (r_state == S_BURST);
    assign w_drain  = (r_state == S_DRAIN);
    assign w_last   = (r_beat == LAST_BEAT);
    assign w_unused = ^bus.cmd_address[OFF_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_base      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            unique case (1'b1)
                w_idle: begin
                    if (bus.cmd_valid) begin
                        r_base  <= bus.cmd_address[ADDR_WIDTH-1:OFF_W];
                        r_beat  <= '0;
                        r_state <= S_BURST;
                    end
                end
                w_burst: begin
                    // An error beat poisons the rest of the line.
                    if (bus.wb_err) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_data  <= '0;
                        r_beat      <= r_beat + 1'b1;
                        r_state     <= w_last ? S_IDLE : S_DRAIN;
                    end else if (bus.wb_ack) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= bus.wb_dat_r;
                        r_beat      <= r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                w_drain: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b1;
                    r_rsp_data  <= '0;
                    r_beat      <= r_beat + 1'b1;
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_idle;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_data  = r_rsp_data;

    assign bus.wb_cyc = w_burst;
    assign bus.wb_stb = w_burst;
    assign bus.wb_adr = w_burst ? {r_base, r_beat} : '0;
    assign bus.wb_cti = w_burst ? cti_for_beat(w_last) : CTI_CLASSIC;
    assign bus.wb_we  = 1'b0;
    assign bus.wb_sel = 4'hF;
    assign bus.wb_bte = BTE_LINEAR;

endmodule

// File: tb/tb_icache_wishbone_refill.sv
// Directed and randomized refills checked against a line-level
// model of the bridge's bus and response behaviour.
module tb_icache_wishbone_refill;

    localparam int LW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    icache_wishbone_refill_if #(.ADDR_WIDTH(AW)) bus ();

    icache_wishbone_refill #(
        .LINE_WORDS(LW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          bus_beat;
    int          waits_left;
    int          err_beat;
    int          max_wait;
    bit          bus_active;
    logic [29:0] exp_base;
    logic [31:0] salt;
    int          ack_cyc[LW];

    logic [31:0] rd_q[$];
    bit          re_q[$];
    int          rc_q[$];
    bit          rr_q[$];

    function automatic logic [31:0] mem(input logic [29:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: slave answers for the coming edge, then sample at negedge.
    task automatic cycle();
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_r = $urandom;
        if (bus.wb_stb !== 1'b1) begin
            bus.wb_ack = 1'($urandom_range(0, 1));
            bus.wb_err = 1'($urandom_range(0, 1));
        end else if (bus_active) begin
            if (waits_left > 0) begin
                waits_left--;
            end else begin
                bus.wb_ack = 1'b1;
                if (bus_beat == err_beat) bus.wb_err = 1'b1;
                else bus.wb_dat_r = mem(bus.wb_adr);
                ack_cyc[bus_beat] = cyc;
                bus_beat++;
                if (bus.wb_err || bus_beat == LW) bus_active = 1'b0;
                waits_left = $urandom_range(0, max_wait);
            end
        end
        @(negedge clk);
        cyc++;
        chk("wb_stb", bus.wb_stb, bus_active);
        chk("wb_cyc", bus.wb_cyc, bus_active);
        if (bus_active) begin
            chk("wb_adr", bus.wb_adr, exp_base + 30'(bus_beat));
            chk("wb_cti", bus.wb_cti, (bus_beat == LW - 1) ? 3'b111 : 3'b010);
        end
        if (bus.rsp_valid === 1'b1) begin
            rd_q.push_back(bus.rsp_data);
            re_q.push_back(bus.rsp_error);
            rc_q.push_back(cyc);
            rr_q.push_back(bus.cmd_ready);
        end
    endtask

    task automatic start_line(input logic [31:0] addr, input int ebeat,
                              input int mw);
        exp_base   = addr[31:2] & ~30'(LW - 1);
        salt       = $urandom;
        bus_beat   = 0;
        bus_active = 1'b1;
        err_beat   = ebeat;
        max_wait   = mw;
        waits_left = $urandom_range(0, mw);
        rd_q.delete();
        re_q.delete();
        rc_q.delete();
        rr_q.delete();
    endtask

    task automatic do_refill(input logic [31:0] addr, input int ebeat,
                             input int mw, input bit pre, input bit hold,
                             input logic [31:0] nxt);
        int acc;
        int n;
        bit e;
        int ec;
        if (!pre) begin
            chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
            bus.cmd_valid   = 1'b1;
            bus.cmd_address = addr;
        end
        start_line(addr, ebeat, mw);
        acc = cyc;
        cycle();
        if (hold) bus.cmd_address = nxt;
        else bus.cmd_valid = 1'b0;
        chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
        n = 0;
        while (rd_q.size() < LW && n < 200) begin
            cycle();
            n++;
        end
        chk("rsp_count", rd_q.size(), LW);
        for (int k = 0; k < LW && k < rd_q.size(); k++) begin
            e  = (ebeat >= 0 && k >= ebeat);
            ec = (e && k > ebeat) ? ack_cyc[ebeat] + 1 + (k - ebeat)
                                  : ack_cyc[k] + 1;
            chk("rsp_error", re_q[k], e);
            chk("rsp_data", rd_q[k], e ? 32'h0 : mem(exp_base + 30'(k)));
            chk("rsp_cycle", rc_q[k], ec);
        end
        if (rr_q.size() > 0) chk("ready_on_last", rr_q[rr_q.size()-1], 1'b1);
        if (mw == 0 && ebeat < 0 && rc_q.size() > 0)
            chk("line_latency", rc_q[rc_q.size()-1] - acc, LW + 1);
    endtask

    initial begin
        int n;
        resetn          = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_address = '0;
        bus.wb_ack      = 1'b0;
        bus.wb_err      = 1'b0;
        bus.wb_dat_r    = '0;
        bus_active      = 1'b0;
        err_beat        = -1;
        max_wait        = 0;
        exp_base        = '0;
        salt            = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_error", bus.rsp_error, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_wb_cyc", bus.wb_cyc, 1'b0);
        chk("rst_wb_adr", bus.wb_adr, 30'h0);
        chk("rst_wb_cti", bus.wb_cti, 3'b000);
        chk("wb_we", bus.wb_we, 1'b0);
        chk("wb_sel", bus.wb_sel, 4'hF);
        chk("wb_bte", bus.wb_bte, 2'b00);
        resetn = 1'b1;

        do_refill(32'h0000_1234, -1, 0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 4; i++)
            do_refill($urandom, -1, 3, 1'b0, 1'b0, '0);

        do_refill(32'h0000_5678, 3, 0, 1'b0, 1'b0, '0);
        do_refill(32'h0000_9ABC, 0, 0, 1'b0, 1'b0, '0);
        do_refill(32'h0000_DEF0, LW - 1, 0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++)
            do_refill($urandom, $urandom_range(0, LW - 1), 2, 1'b0, 1'b0, '0);

        do_refill(32'h0000_0100, -1, 0, 1'b0, 1'b1, 32'h0000_0200);
        do_refill(32'h0000_0200, -1, 0, 1'b1, 1'b0, '0);

        chk("cmd_ready_pre_abort", bus.cmd_ready, 1'b1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_address = 32'h0000_3040;
        start_line(32'h0000_3040, -1, 0);
        cycle();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus_beat < 5 && n < 50) begin
            cycle();
            n++;
        end
        chk("abort_beats", bus_beat, 5);
        #2 resetn = 1'b0;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_rsp_error", bus.rsp_error, 1'b0);
        chk("arst_rsp_data", bus.rsp_data, 32'h0);
        chk("arst_wb_cyc", bus.wb_cyc, 1'b0);
        chk("arst_wb_stb", bus.wb_stb, 1'b0);
        chk("arst_wb_adr", bus.wb_adr, 30'h0);
        chk("arst_wb_cti", bus.wb_cti, 3'b000);
        bus_active = 1'b0;
        rd_q.delete();
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        resetn = 1'b1;
        repeat (4) cycle();
        chk("no_rsp_after_reset", rd_q.size(), 0);

        do_refill(32'h0000_3040, -1, 1, 1'b0, 1'b0, '0);

        rd_q.delete();
        repeat (3) cycle();
        chk("idle_no_rsp", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
